// File: rtl/core_fpu_pkg.sv
// Shared FP scheduler definitions: op classes, default unit latencies, writeback slot payload.
package core_fpu_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_SQRT = 3'd4,
    OP_MISC = 3'd5
  } fpu_op_e;

  localparam int unsigned LAT_ADD_DEF  = 3;
  localparam int unsigned LAT_MUL_DEF  = 4;
  localparam int unsigned LAT_DIV_DEF  = 12;
  localparam int unsigned LAT_MISC_DEF = 1;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] num;
    logic             is_int;
  } wb_slot_t;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_e;

  function automatic logic is_div_op(input fpu_op_e op);
    return (op == OP_DIV) || (op == OP_SQRT);
  endfunction

endpackage

// File: rtl/core_fpu_sched_if.sv
// Issue/start/writeback signal bundle between the FP decoder and the FP scheduler.
interface core_fpu_sched_if;
  import core_fpu_pkg::*;

  logic             ISSUE_VALID;
  fpu_op_e          ISSUE_OP;
  logic [REG_W-1:0] FRS1_NUM;
  logic [REG_W-1:0] FRS2_NUM;
  logic             USE_FRS1;
  logic             USE_FRS2;
  logic [REG_W-1:0] FRD_NUM;
  logic             DST_INT;

  logic             ISSUE_READY;
  logic             START_ADD;
  logic             START_MUL;
  logic             START_DIV;
  logic             START_SQRT;
  logic             START_MISC;
  logic             DIV_BUSY;
  logic             WB_VALID;
  logic [REG_W-1:0] WB_NUM;
  logic             WB_INT;
  logic             FWD_RS1;
  logic             FWD_RS2;

  modport master (
    output ISSUE_VALID, ISSUE_OP, FRS1_NUM, FRS2_NUM, USE_FRS1, USE_FRS2, FRD_NUM, DST_INT,
    input  ISSUE_READY, START_ADD, START_MUL, START_DIV, START_SQRT, START_MISC,
    input  DIV_BUSY, WB_VALID, WB_NUM, WB_INT, FWD_RS1, FWD_RS2
  );

  modport slave (
    input  ISSUE_VALID, ISSUE_OP, FRS1_NUM, FRS2_NUM, USE_FRS1, USE_FRS2, FRD_NUM, DST_INT,
    output ISSUE_READY, START_ADD, START_MUL, START_DIV, START_SQRT, START_MISC,
    output DIV_BUSY, WB_VALID, WB_NUM, WB_INT, FWD_RS1, FWD_RS2
  );

endinterface

// File: rtl/core_fpu_wbres.sv
// Writeback reservation shift register: slot i holds the op writing back i cycles from now.
module core_fpu_wbres
  import core_fpu_pkg::*;
#(
  parameter  int unsigned DEPTH = LAT_DIV_DEF,
  localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins_valid,
  input  logic [LW-1:0]    ins_lat,
  input  logic [REG_W-1:0] ins_num,
  input  logic             ins_int,
  output wb_slot_t         head,
  output logic [DEPTH:0]   busy_vec
);

  wb_slot_t slot_q [DEPTH];
  wb_slot_t slot_d [DEPTH];

  // Shift toward the head; a new op lands so it reaches slot 0 exactly ins_lat cycles later.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      slot_d[i] = slot_q[i+1];
    end
    slot_d[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ins_valid && (ins_lat == LW'(i + 1))) begin
        slot_d[i] = '{valid: 1'b1, num: ins_num, is_int: ins_int};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_q <= slot_d;
    end
  end

  // Top bit stands for "DEPTH cycles from now", which can never already be reserved.
  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_vec[i] = slot_q[i].valid;
    end
  end

  assign head = slot_q[0];

endmodule

// File: rtl/core_fpu_sched.sv
// FP issue scheduler: RAW/WAW scoreboard, writeback-port reservation and shared DIV/SQRT unit.
// Optional operand bypass from the current writeback: define CORE_FPU_SCHED_BYPASS_EN.
module core_fpu_sched
  import core_fpu_pkg::*;
#(
  parameter int unsigned LAT_ADD  = LAT_ADD_DEF,
  parameter int unsigned LAT_MUL  = LAT_MUL_DEF,
  parameter int unsigned LAT_DIV  = LAT_DIV_DEF,
  parameter int unsigned LAT_MISC = LAT_MISC_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  core_fpu_sched_if.slave   fpu
);

  localparam int unsigned LW = $clog2(LAT_DIV + 1);

  logic [NUM_REGS-1:0] sb_q, sb_d;
  wb_slot_t            head;
  logic [LAT_DIV:0]    busy_vec;
  div_state_e          div_state_q, div_state_d;
  logic [LW-1:0]       div_cnt_q, div_cnt_d;

  logic [LW-1:0] op_lat_c;
  logic          wb_fp_c;
  logic          byp1_c, byp2_c, bypd_c;
  logic          raw_c, waw_c, struct_c, div_stall_c;
  logic          is_div_c, div_busy_c, accept_c;

  // Latency of the offered op; zero marks NONE or an unknown encoding.
  always_comb begin
    op_lat_c = '0;
    case (fpu.ISSUE_OP)
      OP_ADD:  op_lat_c = LW'(LAT_ADD);
      OP_MUL:  op_lat_c = LW'(LAT_MUL);
      OP_DIV:  op_lat_c = LW'(LAT_DIV);
      OP_SQRT: op_lat_c = LW'(LAT_DIV);
      OP_MISC: op_lat_c = LW'(LAT_MISC);
      default: op_lat_c = '0;
    endcase
  end

  assign wb_fp_c = head.valid && !head.is_int;

`ifdef CORE_FPU_SCHED_BYPASS_EN
  assign byp1_c = wb_fp_c && (head.num == fpu.FRS1_NUM);
  assign byp2_c = wb_fp_c && (head.num == fpu.FRS2_NUM);
  assign bypd_c = wb_fp_c && (head.num == fpu.FRD_NUM);
`else
  assign byp1_c = 1'b0;
  assign byp2_c = 1'b0;
  assign bypd_c = 1'b0;
`endif

  assign raw_c       = (fpu.USE_FRS1 && sb_q[fpu.FRS1_NUM] && !byp1_c) ||
                       (fpu.USE_FRS2 && sb_q[fpu.FRS2_NUM] && !byp2_c);
  assign waw_c       = !fpu.DST_INT && sb_q[fpu.FRD_NUM] && !bypd_c;
  assign struct_c    = busy_vec[op_lat_c];
  assign is_div_c    = is_div_op(fpu.ISSUE_OP);
  assign div_busy_c  = (div_state_q == DIV_RUN);
  assign div_stall_c = is_div_c && div_busy_c;

  assign accept_c = !RST && fpu.ISSUE_VALID && (op_lat_c != '0) &&
                    !raw_c && !waw_c && !struct_c && !div_stall_c;

  core_fpu_wbres #(
    .DEPTH (LAT_DIV)
  ) u_wbres (
    .clk       (CLK),
    .rst       (RST),
    .ins_valid (accept_c),
    .ins_lat   (op_lat_c),
    .ins_num   (fpu.FRD_NUM),
    .ins_int   (fpu.DST_INT),
    .head      (head),
    .busy_vec  (busy_vec)
  );

  // Clear on writeback first so a same-cycle re-issue of that register keeps its bit set.
  always_comb begin
    sb_d = sb_q;
    if (wb_fp_c) begin
      sb_d[head.num] = 1'b0;
    end
    if (accept_c && !fpu.DST_INT) begin
      sb_d[fpu.FRD_NUM] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= '0;
    end else begin
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
    end
  end

  // Divider occupancy: busy from the cycle after start through its writeback cycle.
  always_comb begin
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    case (div_state_q)
      DIV_IDLE: begin
        if (accept_c && is_div_c) begin
          div_state_d = DIV_RUN;
          div_cnt_d   = LW'(LAT_DIV);
        end
      end
      DIV_RUN: begin
        if (div_cnt_q == LW'(1)) begin
          div_state_d = DIV_IDLE;
          div_cnt_d   = '0;
        end else begin
          div_cnt_d = div_cnt_q - LW'(1);
        end
      end
    endcase
  end

  assign fpu.ISSUE_READY = accept_c;
  assign fpu.START_ADD   = accept_c && (fpu.ISSUE_OP == OP_ADD);
  assign fpu.START_MUL   = accept_c && (fpu.ISSUE_OP == OP_MUL);
  assign fpu.START_DIV   = accept_c && (fpu.ISSUE_OP == OP_DIV);
  assign fpu.START_SQRT  = accept_c && (fpu.ISSUE_OP == OP_SQRT);
  assign fpu.START_MISC  = accept_c && (fpu.ISSUE_OP == OP_MISC);
  assign fpu.DIV_BUSY    = !RST && div_busy_c;
  assign fpu.WB_VALID    = !RST && head.valid;
  assign fpu.WB_NUM      = (RST || !head.valid) ? '0 : head.num;
  assign fpu.WB_INT      = !RST && head.valid && head.is_int;

`ifdef CORE_FPU_SCHED_BYPASS_EN
  assign fpu.FWD_RS1 = accept_c && fpu.USE_FRS1 && byp1_c;
  assign fpu.FWD_RS2 = accept_c && fpu.USE_FRS2 && byp2_c;
`else
  assign fpu.FWD_RS1 = 1'b0;
  assign fpu.FWD_RS2 = 1'b0;
`endif

endmodule

// File: tb/tb_core_fpu_sched.sv
// Directed scoreboard bench for core_fpu_sched; expectations track CORE_FPU_SCHED_BYPASS_EN.
module tb_core_fpu_sched;
  import core_fpu_pkg::*;

`ifdef CORE_FPU_SCHED_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [4:0] num;
    logic       is_int;
  } exp_wb_t;

  logic clk = 1'b0;
  logic rst;
  core_fpu_sched_if bus ();

  core_fpu_sched #(
    .LAT_ADD  (LAT_ADD_DEF),
    .LAT_MUL  (LAT_MUL_DEF),
    .LAT_DIV  (LAT_DIV_DEF),
    .LAT_MISC (LAT_MISC_DEF)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .fpu (bus)
  );

  always #5 clk = ~clk;

  int         cyc     = 0;
  int         n_pass  = 0;
  int         n_chk   = 0;
  int         busy_lo = 1;
  int         busy_hi = 0;
  exp_wb_t    wbq[$];
  fpu_op_e    cur_op  = OP_NONE;
  logic [4:0] cur_rd  = '0;
  logic       cur_int = 1'b0;

  function automatic int lat_of(input fpu_op_e op);
    case (op)
      OP_ADD:  return LAT_ADD_DEF;
      OP_MUL:  return LAT_MUL_DEF;
      OP_DIV:  return LAT_DIV_DEF;
      OP_SQRT: return LAT_DIV_DEF;
      OP_MISC: return LAT_MISC_DEF;
      default: return 0;
    endcase
  endfunction

  function automatic logic [4:0] start_of(input fpu_op_e op);
    case (op)
      OP_ADD:  return 5'b10000;
      OP_MUL:  return 5'b01000;
      OP_DIV:  return 5'b00100;
      OP_SQRT: return 5'b00010;
      OP_MISC: return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic offer(input fpu_op_e op, input logic [4:0] rd, input logic dint,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2);
    bus.ISSUE_VALID = 1'b1;
    bus.ISSUE_OP    = op;
    bus.FRD_NUM     = rd;
    bus.DST_INT     = dint;
    bus.FRS1_NUM    = rs1;
    bus.USE_FRS1    = u1;
    bus.FRS2_NUM    = rs2;
    bus.USE_FRS2    = u2;
    cur_op  = op;
    cur_rd  = rd;
    cur_int = dint;
  endtask

  // One clock cycle: check outputs mid-cycle, record an expected accept, then advance.
  task automatic tick(input logic exp_rdy, input logic exp_f1);
    int idx;
    exp_wb_t e;
    @(negedge clk);
    chk("issue_ready", 32'(bus.ISSUE_READY), 32'(exp_rdy));
    chk("start_vec", 32'({bus.START_ADD, bus.START_MUL, bus.START_DIV, bus.START_SQRT, bus.START_MISC}),
        32'(exp_rdy ? start_of(cur_op) : 5'b0));
    chk("fwd_rs", 32'({bus.FWD_RS1, bus.FWD_RS2}), 32'({exp_f1, 1'b0}));
    chk("div_busy", 32'(bus.DIV_BUSY), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
    idx = -1;
    foreach (wbq[i]) if (wbq[i].cyc == cyc) idx = i;
    if (idx >= 0) begin
      chk("wb_valid", 32'(bus.WB_VALID), 32'd1);
      chk("wb_num", 32'(bus.WB_NUM), 32'(wbq[idx].num));
      chk("wb_int", 32'(bus.WB_INT), 32'(wbq[idx].is_int));
      wbq.delete(idx);
    end else begin
      chk("wb_idle", 32'(bus.WB_VALID), 32'd0);
    end
    if (rst) chk("rst_wb_fields", 32'({bus.WB_NUM, bus.WB_INT}), 32'd0);
    if (exp_rdy) begin
      e.cyc    = cyc + lat_of(cur_op);
      e.num    = cur_rd;
      e.is_int = cur_int;
      wbq.push_back(e);
      if (cur_op == OP_DIV || cur_op == OP_SQRT) begin
        busy_lo = cyc + 1;
        busy_hi = cyc + LAT_DIV_DEF;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (exp_rdy) bus.ISSUE_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.ISSUE_VALID = 1'b0;
    repeat (n) tick(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.ISSUE_VALID = 1'b0;
    bus.ISSUE_OP    = OP_NONE;
    bus.FRD_NUM     = '0;
    bus.DST_INT     = 1'b0;
    bus.FRS1_NUM    = '0;
    bus.USE_FRS1    = 1'b0;
    bus.FRS2_NUM    = '0;
    bus.USE_FRS2    = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rst = 1'b0;

    // ADD f1: start now, writeback 3 later, f1 readable again the cycle after
    offer(OP_ADD, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(1'b1, 1'b0);
    idle(3);
    offer(OP_ADD, 5'd8, 1'b0, 5'd1, 1'b1, 5'd1, 1'b1);
    tick(1'b1, 1'b0);
    idle(5);

    // RAW on f2 behind ADD f2 / MUL f3; released in f2's writeback cycle only with bypass
    offer(OP_ADD, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(1'b1, 1'b0);
    offer(OP_MUL, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(1'b1, 1'b0);
    offer(OP_ADD, 5'd9, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0);
    tick(1'b0, 1'b0);
    tick(BYP, BYP);
    tick(!BYP, 1'b0);
    idle(8);

    // Writeback-port collision: ADD would land with MUL f4, slips one cycle
    offer(OP_MUL, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(1'b1, 1'b0);
    offer(OP_ADD, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    idle(6);

    // DIV f6 then SQRT f7: SQRT waits out the whole divider occupancy
    offer(OP_DIV, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(1'b1, 1'b0);
    offer(OP_SQRT, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    repeat (12) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    idle(14);

    // Integer-destination FEQ to rd 6 passes a pending f6; FP write or read of f6 stalls
    offer(OP_DIV, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(1'b1, 1'b0);
    offer(OP_MISC, 5'd6, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1);
    tick(1'b1, 1'b0);
    offer(OP_ADD, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    offer(OP_ADD, 5'd12, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0);
    tick(1'b0, 1'b0);
    idle(12);

    // Reset in the middle of a DIV drops it; a new DIV goes at the first cycle after release
    offer(OP_DIV, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(1'b1, 1'b0);
    idle(4);
    rst = 1'b1;
    wbq.delete();
    busy_lo = 1;
    busy_hi = 0;
    offer(OP_DIV, 5'd13, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rst = 1'b0;
    tick(1'b1, 1'b0);
    idle(14);

    chk("wb_queue_drained", 32'(wbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
